// File: rtl/display_pkg.sv
// Shared types and constants for the CPU output seven-segment display.
// Holds the converter FSM state enum, the active-low segment codes
// ({g,f,e,d,c,b,a}), bus widths, and the segment decode and
// double-dabble step helpers.
package display_pkg;

  localparam int unsigned BIN_W   = 8;
  localparam int unsigned BCD_W   = 12;
  localparam int unsigned SHREG_W = BCD_W + BIN_W;
  localparam int unsigned SEG_W   = 7;
  localparam int unsigned DIGITS  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_t;

  localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_MINUS = 7'b0111111;

  // BCD nibble to active-low segment pattern; non-decimal codes blank.
  function automatic logic [SEG_W-1:0] seg_decode(input logic [3:0] nib);
    logic [SEG_W-1:0] s;
    case (nib)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // One double-dabble iteration: add 3 to each BCD nibble >= 5, then shift left.
  function automatic logic [SHREG_W-1:0] dd_step(input logic [SHREG_W-1:0] s);
    logic [SHREG_W-1:0] t;
    t = s;
    for (int i = 0; i < 3; i++) begin
      if (t[BIN_W + 4*i +: 4] >= 4'd5) begin
        t[BIN_W + 4*i +: 4] = t[BIN_W + 4*i +: 4] + 4'd3;
      end
    end
    return {t[SHREG_W-2:0], 1'b0};
  endfunction

endpackage

// File: rtl/cpu_out_display_if.sv
// Bus between the CPU output and the seven-segment display driver.
//   dataIn : value to display (driven by master)
//   anode  : active-low digit enables, bit 0 = rightmost digit
//   seg    : active-low segments {g,f,e,d,c,b,a}
//   dp     : active-low decimal point
//   busy   : conversion in progress
interface cpu_out_display_if;
  import display_pkg::*;

  logic [BIN_W-1:0]  dataIn;
  logic [DIGITS-1:0] anode;
  logic [SEG_W-1:0]  seg;
  logic              dp;
  logic              busy;

  modport master (output dataIn, input anode, seg, dp, busy);
  modport slave  (input dataIn, output anode, seg, dp, busy);
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Iterative double-dabble binary-to-BCD converter.
// Watches data_in and reconverts whenever it differs from the last accepted
// value; the committed result is held in bcd_reg until the next DONE.
// Optional feature macro: DISPLAY_SIGNED_EN (two's-complement input, converts
// the magnitude and exports the sign).
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   data_in    : binary value to convert
//   bcd_reg    : committed {hundreds, tens, ones}
//   sign       : committed sign (always 0 when unsigned)
//   busy       : high while state != IDLE
module bin_to_bcd_seq
  import display_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [BIN_W-1:0] data_in,
  output logic [BCD_W-1:0] bcd_reg,
  output logic             sign,
  output logic             busy
);

  conv_state_t        state, state_d;
  logic [BIN_W-1:0]   last_value, last_value_d;
  logic [BIN_W-1:0]   magnitude;
  logic [SHREG_W-1:0] shreg, shreg_d;
  logic [2:0]         bit_count, bit_count_d;
  logic [BCD_W-1:0]   bcd_d;
  logic               sign_d;

  // -128 negates to 0x80, which reads correctly as unsigned 128.
`ifdef DISPLAY_SIGNED_EN
  assign magnitude = data_in[BIN_W-1] ? (~data_in + BIN_W'(1)) : data_in;
`else
  assign magnitude = data_in;
`endif

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_value <= '0;
      shreg      <= '0;
      bit_count  <= '0;
      bcd_reg    <= '0;
      sign       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_d;
      last_value <= last_value_d;
      shreg      <= shreg_d;
      bit_count  <= bit_count_d;
      bcd_reg    <= bcd_d;
      sign       <= sign_d;
      busy       <= (state_d != IDLE);
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d      = state;
    last_value_d = last_value;
    shreg_d      = shreg;
    bit_count_d  = bit_count;
    bcd_d        = bcd_reg;
    sign_d       = sign;
    case (state)
      IDLE: begin
        if (data_in != last_value) begin
          last_value_d = data_in;
          shreg_d      = {BCD_W'(0), magnitude};
          bit_count_d  = '0;
          state_d      = SHIFT;
        end
      end
      SHIFT: begin
        shreg_d     = dd_step(shreg);
        bit_count_d = bit_count + 3'd1;
        if (bit_count == 3'd7) begin
          state_d = DONE;
        end
      end
      DONE: begin
        bcd_d   = shreg[SHREG_W-1:BIN_W];
`ifdef DISPLAY_SIGNED_EN
        sign_d  = last_value[BIN_W-1];
`else
        sign_d  = 1'b0;
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/cpu_out_display.sv
// Four-digit multiplexed seven-segment driver for the CPU output bus.
// Converts dataIn to decimal, scans digits with a refresh counter and
// blanks leading zeros. Digit 3 shows a minus sign for negative values
// when built with DISPLAY_SIGNED_EN; otherwise it is always blank.
// Ports:
//   boardCLK : single clock, rising edge
//   reset    : synchronous active-high reset
//   bus      : slave side of cpu_out_display_if (dataIn in; anode, seg,
//              dp, busy out)
// Parameter SCAN_CYCLES: clock cycles each digit stays lit (>= 1).
module cpu_out_display
  import display_pkg::*;
#(
  parameter int unsigned SCAN_CYCLES = 50000
) (
  input  logic             boardCLK,
  input  logic             reset,
  cpu_out_display_if.slave bus
);

  localparam int unsigned CNT_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_CYCLES - 1);

  logic [BCD_W-1:0]  bcd_reg;
  logic              sign;
  logic              conv_busy;
  logic [CNT_W-1:0]  scan_count, scan_count_d;
  logic [1:0]        digit_idx, digit_idx_d;
  logic [DIGITS-1:0] anode_q, anode_d;
  logic [SEG_W-1:0]  seg_q, seg_d;
  logic [3:0]        ones, tens, hundreds;

  bin_to_bcd_seq u_conv (
    .clk     (boardCLK),
    .reset   (reset),
    .data_in (bus.dataIn),
    .bcd_reg (bcd_reg),
    .sign    (sign),
    .busy    (conv_busy)
  );

  assign ones     = bcd_reg[3:0];
  assign tens     = bcd_reg[7:4];
  assign hundreds = bcd_reg[11:8];

  // Scan counter, digit index and registered display outputs.
  always_ff @(posedge boardCLK) begin
    if (reset) begin
      scan_count <= '0;
      digit_idx  <= '0;
      anode_q    <= '1;
      seg_q      <= SEG_BLANK;
    end else begin
      scan_count <= scan_count_d;
      digit_idx  <= digit_idx_d;
      anode_q    <= anode_d;
      seg_q      <= seg_d;
    end
  end

  // Scan advance, anode select and per-digit content with zero blanking.
  always_comb begin
    scan_count_d = scan_count + CNT_W'(1);
    digit_idx_d  = digit_idx;
    if (scan_count == SCAN_LAST) begin
      scan_count_d = '0;
      digit_idx_d  = digit_idx + 2'd1;
    end

    anode_d = ~(DIGITS'(1) << digit_idx);

    seg_d = SEG_BLANK;
    case (digit_idx)
      2'd0: seg_d = seg_decode(ones);
      2'd1: if ((hundreds != 4'd0) || (tens != 4'd0)) seg_d = seg_decode(tens);
      2'd2: if (hundreds != 4'd0) seg_d = seg_decode(hundreds);
      // sign is held at 0 in the unsigned build, so this digit stays blank.
      2'd3: seg_d = sign ? SEG_MINUS : SEG_BLANK;
      default: seg_d = SEG_BLANK;
    endcase
  end

  assign bus.anode = anode_q;
  assign bus.seg   = seg_q;
  assign bus.dp    = 1'b1;
  assign bus.busy  = conv_busy;

endmodule

// File: tb/tb_cpu_out_display.sv
// Directed bench for cpu_out_display with SCAN_CYCLES = 4.
module tb_cpu_out_display;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  cpu_out_display_if bus();

  cpu_out_display #(.SCAN_CYCLES(4)) dut (
    .boardCLK (clk),
    .reset    (reset),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  // Wait until the scan lights digit d, return the segments seen then.
  task automatic grab_digit(input int d, output logic [6:0] s, output bit found);
    logic [3:0] want_an;
    want_an = ~(4'b0001 << d);
    found = 1'b0;
    s = 7'h7f;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.anode === want_an) begin
        s = bus.seg;
        found = 1'b1;
        break;
      end
    end
  endtask

  // Apply a value and wait for the conversion it triggers to finish.
  task automatic convert(input logic [7:0] v, output int busy_cycles, output bit ok);
    bit seen;
    seen = 1'b0;
    ok = 1'b0;
    busy_cycles = 0;
    bus.dataIn = v;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.busy === 1'b1) begin
        seen = 1'b1;
        busy_cycles++;
      end else if (seen) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [6:0] s;
    bit f;
    reset = 1'b1;
    bus.dataIn = 8'd0;
    @(negedge clk);
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (bus.anode !== 4'b1111) begin bad++; $display("FAIL reset_anode: got %b want 1111", bus.anode); end
    total++;
    if (bus.seg !== 7'b1111111) begin bad++; $display("FAIL reset_seg: got %b want 1111111", bus.seg); end
    total++;
    if (bus.busy !== 1'b0 || bus.dp !== 1'b1) begin
      bad++; $display("FAIL reset_busy_dp: got busy=%b dp=%b want busy=0 dp=1", bus.busy, bus.dp);
    end
    reset = 1'b0;
    grab_digit(0, s, f);
    total++;
    if (!f || s !== 7'b1000000) begin bad++; $display("FAIL reset_d0: got %b found=%0d want 1000000", s, f); end
    for (int d = 1; d < 4; d++) begin
      grab_digit(d, s, f);
      total++;
      if (!f || s !== 7'b1111111) begin bad++; $display("FAIL reset_d%0d: got %b found=%0d want 1111111", d, s, f); end
    end
  endtask

  task automatic test_scan_timing();
    logic [3:0] v;
    int n;
    bit changed;
    changed = 1'b0;
    v = bus.anode;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.anode !== v) begin changed = 1'b1; break; end
    end
    v = bus.anode;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      n++;
      @(posedge clk);
      @(negedge clk);
      if (bus.anode !== v) break;
    end
    total++;
    if (!changed || n != 4) begin bad++; $display("FAIL scan_dwell: got %0d cycles want 4", n); end
    total++;
    if (bus.anode !== {v[2:0], v[3]}) begin
      bad++; $display("FAIL scan_order: got %b want %b", bus.anode, {v[2:0], v[3]});
    end
  endtask

  task automatic test_conversion();
    logic [6:0] s;
    bit f, ok;
    int n;
    logic [6:0] exp_d [4];
    exp_d[0] = 7'b0010010;
    exp_d[1] = 7'b0010010;
    exp_d[2] = 7'b0100100;
    exp_d[3] = 7'b1111111;
    convert(8'hFF, n, ok);
    total++;
    if (!ok || n != 9) begin bad++; $display("FAIL conv_busy_len: got %0d ok=%0d want 9", n, ok); end
    total++;
    if (dut.u_conv.bcd_reg !== 12'h255) begin bad++; $display("FAIL conv_bcd: got %h want 255", dut.u_conv.bcd_reg); end
    for (int d = 0; d < 4; d++) begin
      grab_digit(d, s, f);
      total++;
      if (!f || s !== exp_d[d]) begin bad++; $display("FAIL conv_d%0d: got %b want %b", d, s, exp_d[d]); end
    end
  endtask

  task automatic test_blanking();
    logic [6:0] s;
    bit f, ok;
    int n;
    logic [6:0] exp7 [4];
    logic [6:0] exp40 [4];
    exp7[0] = 7'b1111000; exp7[1] = 7'b1111111; exp7[2] = 7'b1111111; exp7[3] = 7'b1111111;
    exp40[0] = 7'b1000000; exp40[1] = 7'b0011001; exp40[2] = 7'b1111111; exp40[3] = 7'b1111111;
    convert(8'd7, n, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL blank7_done: got timeout want done"); end
    for (int d = 0; d < 4; d++) begin
      grab_digit(d, s, f);
      total++;
      if (!f || s !== exp7[d]) begin bad++; $display("FAIL blank7_d%0d: got %b want %b", d, s, exp7[d]); end
    end
    convert(8'd40, n, ok);
    for (int d = 0; d < 4; d++) begin
      grab_digit(d, s, f);
      total++;
      if (!ok || !f || s !== exp40[d]) begin bad++; $display("FAIL blank40_d%0d: got %b want %b", d, s, exp40[d]); end
    end
  endtask

  task automatic test_change_while_busy();
    logic [6:0] s;
    bit f, ok;
    int n;
    logic [6:0] exp_d [3];
    exp_d[0] = 7'b1000000; exp_d[1] = 7'b1000000; exp_d[2] = 7'b0100100;
    bus.dataIn = 8'd12;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (bus.busy !== 1'b1) begin bad++; $display("FAIL cwb_accept: got busy=%b want 1", bus.busy); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    bus.dataIn = 8'd200;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.busy === 1'b0) begin ok = 1'b1; break; end
      @(posedge clk);
      @(negedge clk);
    end
    total++;
    if (!ok || dut.u_conv.bcd_reg !== 12'h012) begin
      bad++; $display("FAIL cwb_first: got %h ok=%0d want 012", dut.u_conv.bcd_reg, ok);
    end
    @(posedge clk);
    @(negedge clk);
    total++;
    if (bus.busy !== 1'b1) begin bad++; $display("FAIL cwb_restart: got busy=%b want 1", bus.busy); end
    convert(8'd200, n, ok);
    total++;
    if (!ok || dut.u_conv.bcd_reg !== 12'h200) begin
      bad++; $display("FAIL cwb_second: got %h ok=%0d want 200", dut.u_conv.bcd_reg, ok);
    end
    for (int d = 0; d < 3; d++) begin
      grab_digit(d, s, f);
      total++;
      if (!f || s !== exp_d[d]) begin bad++; $display("FAIL cwb_d%0d: got %b want %b", d, s, exp_d[d]); end
    end
  endtask

  task automatic test_signed();
    logic [6:0] s;
    bit f, ok;
    int n;
    logic [6:0] exp_a [4];
    logic [6:0] exp_b [4];
    exp_a[0] = 7'b0000000; exp_a[1] = 7'b0100100; exp_a[2] = 7'b1111001;
`ifdef DISPLAY_SIGNED_EN
    exp_a[3] = 7'b0111111;
`else
    exp_a[3] = 7'b1111111;
`endif
    exp_b[0] = 7'b0010010; exp_b[1] = 7'b1111111; exp_b[2] = 7'b1111111; exp_b[3] = 7'b1111111;
    convert(8'h80, n, ok);
    total++;
    if (!ok || dut.u_conv.bcd_reg !== 12'h128) begin
      bad++; $display("FAIL sgn_bcd: got %h ok=%0d want 128", dut.u_conv.bcd_reg, ok);
    end
    for (int d = 0; d < 4; d++) begin
      grab_digit(d, s, f);
      total++;
      if (!f || s !== exp_a[d]) begin bad++; $display("FAIL sgn80_d%0d: got %b want %b", d, s, exp_a[d]); end
    end
    convert(8'h05, n, ok);
    for (int d = 0; d < 4; d++) begin
      grab_digit(d, s, f);
      total++;
      if (!ok || !f || s !== exp_b[d]) begin bad++; $display("FAIL sgn05_d%0d: got %b want %b", d, s, exp_b[d]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [6:0] s;
    bit f, ok;
    int n;
    logic [6:0] exp_d [3];
    exp_d[0] = 7'b0010000; exp_d[1] = 7'b0010000; exp_d[2] = 7'b1111111;
    bus.dataIn = 8'd99;
    @(posedge clk);
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (bus.busy !== 1'b1) begin bad++; $display("FAIL rmid_in_shift: got busy=%b want 1", bus.busy); end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (bus.busy !== 1'b0 || dut.u_conv.bcd_reg !== 12'h000 || bus.anode !== 4'b1111) begin
      bad++; $display("FAIL rmid_reset: got busy=%b bcd=%h anode=%b want 0 000 1111",
                      bus.busy, dut.u_conv.bcd_reg, bus.anode);
    end
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (bus.busy !== 1'b1) begin bad++; $display("FAIL rmid_restart: got busy=%b want 1", bus.busy); end
    convert(8'd99, n, ok);
    total++;
    if (!ok || dut.u_conv.bcd_reg !== 12'h099) begin
      bad++; $display("FAIL rmid_bcd: got %h ok=%0d want 099", dut.u_conv.bcd_reg, ok);
    end
    for (int d = 0; d < 3; d++) begin
      grab_digit(d, s, f);
      total++;
      if (!f || s !== exp_d[d]) begin bad++; $display("FAIL rmid_d%0d: got %b want %b", d, s, exp_d[d]); end
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.dataIn = 8'd0;
    test_reset();
    test_scan_timing();
    test_conversion();
    test_blanking();
    test_change_while_busy();
    test_signed();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
